// File: rtl/switchbox_config_loader_pkg.sv
// Shared definitions for the switch box configuration loader.
package config_pkg;

   localparam int unsigned SB_CONFIG_WIDTH = 24;

   // Field offsets inside the switch box configuration word.
   localparam int unsigned SB_NORTH_OFS  = 0;
   localparam int unsigned SB_EAST_OFS   = 4;
   localparam int unsigned SB_SOUTH_OFS  = 8;
   localparam int unsigned SB_WEST_OFS   = 12;
   localparam int unsigned SB_LEMUX_OFS  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      PARITY = 3'd2,
      COMMIT = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_e;

endpackage

// File: rtl/switchbox_config_loader_shift_register.sv
// Shadow shift register, accepted-bit counter and running parity for the loader.
module config_shift_register
   import config_pkg::*;
#(
   parameter int unsigned CONFIG_WIDTH = SB_CONFIG_WIDTH,
   parameter int unsigned COUNT_WIDTH  = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    shift_enable_i,
   input  logic                    bit_i,
   output logic [CONFIG_WIDTH-1:0] shadow_o,
   output logic [COUNT_WIDTH-1:0]  count_o,
   output logic                    parity_o
);

   logic [CONFIG_WIDTH-1:0] shadow_q;
   logic [COUNT_WIDTH-1:0]  count_q;
   logic                    parity_q;

   // MSB-first shift of data bits; clear restarts count and parity for a new word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         count_q  <= '0;
         parity_q <= 1'b0;
      end else if (clear_i) begin
         count_q  <= '0;
         parity_q <= 1'b0;
      end else if (shift_enable_i) begin
         shadow_q <= {shadow_q[CONFIG_WIDTH-2:0], bit_i};
         count_q  <= count_q + 1'b1;
         parity_q <= parity_q ^ bit_i;
      end
   end

   assign shadow_o = shadow_q;
   assign count_o  = count_q;
   assign parity_o = parity_q;

endmodule

// File: rtl/switchbox_config_loader.sv
// Serial config loader: deserialises, parity-checks and atomically commits a switch box word.
module switchbox_config_loader
   import config_pkg::*;
#(
   parameter int unsigned CONFIG_WIDTH = SB_CONFIG_WIDTH,
   parameter int unsigned COUNT_WIDTH  = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    config_bit_in,
   input  logic                    config_valid_in,
   output logic                    config_ready_out,
   output logic [CONFIG_WIDTH-1:0] config_out,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   state_e                  state_q, state_d;
   logic                    error_q;
   logic [CONFIG_WIDTH-1:0] config_q;

   logic                    clear;
   logic                    shift_enable;
   logic                    ready;
   logic [CONFIG_WIDTH-1:0] shadow;
   logic [COUNT_WIDTH-1:0]  count;
   logic                    parity;

   config_shift_register #(
      .CONFIG_WIDTH (CONFIG_WIDTH),
      .COUNT_WIDTH  (COUNT_WIDTH)
   ) u_shift (
      .clk_i          (clock),
      .rst_i          (reset),
      .clear_i        (clear),
      .shift_enable_i (shift_enable),
      .bit_i          (config_bit_in),
      .shadow_o       (shadow),
      .count_o        (count),
      .parity_o       (parity)
   );

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake decode; the parity bit is judged combinationally so it never enters the shadow.
   always_comb begin
      state_d      = state_q;
      clear        = 1'b0;
      shift_enable = 1'b0;
      ready        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            ready = 1'b1;
            if (config_valid_in) begin
               shift_enable = 1'b1;
               if (count == COUNT_WIDTH'(CONFIG_WIDTH - 1)) state_d = PARITY;
            end
         end
         PARITY: begin
            ready = 1'b1;
            if (config_valid_in) begin
               if ((parity ^ config_bit_in) == 1'b0) state_d = COMMIT;
               else                                  state_d = ERROR;
            end
         end
         COMMIT:  state_d = DONE;
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sticky parity error: cleared by an accepted start, set when leaving ERROR.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                          error_q <= 1'b0;
      else if (state_q == IDLE && start)  error_q <= 1'b0;
      else if (state_q == ERROR)          error_q <= 1'b1;
   end

   // Active configuration, updated only from COMMIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                  config_q <= '0;
      else if (state_q == COMMIT) config_q <= shadow;
   end

   assign config_ready_out = ready;
   assign config_out       = config_q;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign error            = error_q;

endmodule

// File: tb/tb_switchbox_config_loader.sv
// Self-checking bench for switchbox_config_loader: directed scenarios plus randomized words.
module tb_switchbox_config_loader;

   localparam int unsigned W = 24;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         config_bit_in = 1'b0;
   logic         config_valid_in = 1'b0;
   logic         config_ready_out;
   logic [W-1:0] config_out;
   logic         busy;
   logic         done;
   logic         error;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   int unsigned  acc_count = 0;
   logic [W-1:0] exp_cfg = '0;

   switchbox_config_loader #(
      .CONFIG_WIDTH (W),
      .COUNT_WIDTH  (5)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .config_bit_in    (config_bit_in),
      .config_valid_in  (config_valid_in),
      .config_ready_out (config_ready_out),
      .config_out       (config_out),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clock = ~clock;

   // Counts every handshake the DUT accepts.
   always @(posedge clock) begin
      if (config_valid_in === 1'b1 && config_ready_out === 1'b1) acc_count <= acc_count + 1;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one bit and wait (bounded) for it to be accepted; returns at the following negedge.
   task automatic send_bit(input logic b, input logic pulse_start);
      int unsigned waited = 0;
      config_bit_in   = b;
      config_valid_in = 1'b1;
      if (pulse_start) start = 1'b1;
      while (config_ready_out !== 1'b1 && waited < 50) begin
         @(negedge clock);
         waited++;
      end
      chk("handshake_timeout", W'(waited < 50), W'(1));
      @(negedge clock);
      start = 1'b0;
   endtask

   // Full transaction against the reference model: a word commits only if data+parity has even parity.
   task automatic load_word(input logic [W-1:0] w, input logic p,
                            input int stall_every, input int stall_len,
                            input int mid_start_idx, input logic start_on_done);
      logic good;
      logic b;
      good = ~(^{w, p});
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_after_start", W'(busy), W'(1));
      chk("error_cleared_by_start", W'(error), W'(0));
      for (int i = 0; i < 25; i++) begin
         b = (i < 24) ? w[23 - i] : p;
         send_bit(b, i == mid_start_idx);
         if (stall_every > 0 && i < 24 && ((i + 1) % stall_every) == 0) begin
            config_valid_in = 1'b0;
            repeat (stall_len) @(negedge clock);
         end
      end
      config_valid_in = 1'b0;
      chk("no_done_before_commit", W'(done), W'(0));
      chk("cfg_unchanged_before_commit", config_out, exp_cfg);
      chk("busy_after_parity", W'(busy), W'(1));
      if (good) exp_cfg = w;
      @(negedge clock);
      chk("done_pulse", W'(done), W'(good));
      chk("cfg_after_commit", config_out, exp_cfg);
      if (start_on_done) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("done_single", W'(done), W'(0));
      chk("busy_end", W'(busy), W'(0));
      chk("error_flag", W'(error), W'(!good));
      chk("ready_idle", W'(config_ready_out), W'(0));
      chk("cfg_final", config_out, exp_cfg);
   endtask

   initial begin
      int unsigned acc_before;
      logic [W-1:0] rw;
      logic rp;

      // Reset state
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_cfg", config_out, '0);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_error", W'(error), W'(0));
      chk("rst_ready", W'(config_ready_out), W'(0));

      // Valid presented while idle is ignored
      config_valid_in = 1'b1;
      config_bit_in = 1'b1;
      repeat (3) @(negedge clock);
      config_valid_in = 1'b0;
      chk("idle_valid_ignored", W'(busy), W'(0));

      // Good word, valid held high
      load_word(24'hA5C3F0, 1'b0, 0, 0, -1, 1'b0);
      // Same word with bad parity
      load_word(24'hA5C3F0, 1'b1, 0, 0, -1, 1'b0);
      // Stalled load; also clears the sticky error
      acc_before = acc_count;
      load_word(24'h000001, 1'b1, 5, 3, -1, 1'b0);
      chk("accepted_bits", W'(acc_count - acc_before), W'(25));

      // Asynchronous reset in the middle of a load
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      exp_cfg = '0;
      chk("arst_cfg", config_out, '0);
      chk("arst_busy", W'(busy), W'(0));
      chk("arst_done", W'(done), W'(0));
      chk("arst_error", W'(error), W'(0));
      chk("arst_ready", W'(config_ready_out), W'(0));
      config_valid_in = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      load_word(24'hFFFFFF, 1'b0, 0, 0, -1, 1'b0);

      // Start pulses mid-LOAD and on the done cycle are ignored
      load_word(24'h3C5A96, ^24'h3C5A96, 0, 0, 10, 1'b1);
      @(negedge clock);
      chk("no_extra_load", W'(busy), W'(0));
      chk("cfg_kept", config_out, exp_cfg);

      // Randomized words, parity and stall patterns
      for (int n = 0; n < 12; n++) begin
         rw = W'($urandom);
         rp = ($urandom_range(0, 3) == 0) ? ~(^rw) : (^rw);
         load_word(rw, rp, int'($urandom_range(0, 6)), int'($urandom_range(1, 4)), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
